// File: rtl/clk_div_adc_multi_if.sv
// clk_div_adc_multi_if: control and status bundle for the multi-channel divider/timer
interface clk_div_adc_multi_if #(
  parameter int Width    = 8,
  parameter int Channels = 4
);
  logic                        sync_i;
  logic [Channels-1:0]         en_i;
  logic [Channels*Width-1:0]   kmax_i;
  logic [2*Channels-1:0]       mode_i;
  logic [Channels-1:0]         start_i;
  logic [Channels-1:0]         tick_o;
  logic [Channels-1:0]         sq_o;
  logic [Channels-1:0]         busy_o;
  modport master (
    output sync_i, en_i, kmax_i, mode_i, start_i,
    input  tick_o, sq_o, busy_o
  );
  modport slave (
    input  sync_i, en_i, kmax_i, mode_i, start_i,
    output tick_o, sq_o, busy_o
  );
endinterface

// File: rtl/clk_div_adc_multi.sv
// clk_div_adc_multi: per-channel down-counter dividers (off / periodic / one-shot / square)
module clk_div_adc_multi #(
  parameter int Width    = 8,
  parameter int Channels = 4
) (
  input logic                  clk_i,
  input logic                  rst_i,
  clk_div_adc_multi_if.slave   bus
);
  localparam logic [1:0] M_OFF = 2'b00;
  localparam logic [1:0] M_PER = 2'b01;
  localparam logic [1:0] M_ONE = 2'b10;
  localparam logic [1:0] M_SQ  = 2'b11;
  logic [Channels-1:0][Width-1:0] cnt_q, cnt_d, kmax_in;
  logic [Channels-1:0][1:0]       mode_q, mode_d, mode_in, mode_cur;
  logic [Channels-1:0]            busy_q, busy_d, sq_q, sq_d, tick_q, tick_d;
  logic                           first_q, first_d;
  // The first edge after reset adopts mode_i directly, so it runs as normal operation
  // instead of being consumed by a mode-change clear.
  for (genvar g = 0; g < Channels; g++) begin : g_ch
    assign kmax_in[g]  = bus.kmax_i[g*Width +: Width];
    assign mode_in[g]  = bus.mode_i[2*g +: 2];
    assign mode_cur[g] = first_q ? mode_in[g] : mode_q[g];
  end
  // Next-state: sync_i, then mode change, then the per-mode counting behaviour
  always_comb begin
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    sq_d    = sq_q;
    tick_d  = '0;
    mode_d  = mode_in;
    first_d = 1'b0;
    for (int n = 0; n < Channels; n++) begin
      if (bus.sync_i || mode_in[n] != mode_cur[n]) begin
        cnt_d[n]  = '0;
        busy_d[n] = 1'b0;
        sq_d[n]   = 1'b0;
      end else begin
        case (mode_cur[n])
          M_PER, M_SQ: begin
            if (bus.en_i[n]) begin
              if (cnt_q[n] == '0) begin
                cnt_d[n]  = kmax_in[n];
                tick_d[n] = 1'b1;
                sq_d[n]   = (mode_cur[n] == M_SQ) ? ~sq_q[n] : 1'b0;
              end else begin
                cnt_d[n] = cnt_q[n] - 1'b1;
              end
            end
          end
          M_ONE: begin
            if (!busy_q[n]) begin
              cnt_d[n]  = bus.start_i[n] ? kmax_in[n] : '0;
              busy_d[n] = bus.start_i[n];
            end else if (bus.en_i[n]) begin
              if (cnt_q[n] == '0) begin
                busy_d[n] = 1'b0;
                tick_d[n] = 1'b1;
              end else begin
                cnt_d[n] = cnt_q[n] - 1'b1;
              end
            end
          end
          default: begin
            cnt_d[n]  = '0;
            busy_d[n] = 1'b0;
            sq_d[n]   = 1'b0;
          end
        endcase
      end
    end
  end
  // State registers, cleared asynchronously by the active-low reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      busy_q  <= '0;
      sq_q    <= '0;
      tick_q  <= '0;
      mode_q  <= '0;
      first_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      sq_q    <= sq_d;
      tick_q  <= tick_d;
      mode_q  <= mode_d;
      first_q <= first_d;
    end
  end
  assign bus.tick_o = tick_q;
  assign bus.sq_o   = sq_q;
  assign bus.busy_o = busy_q;
endmodule

// File: doc/clk_div_adc_multi.md
Name: clk_div_adc_multi

Overview:
- Multi-channel programmable divider/timer for the ADC and bolometer-matrix sequencing path.
- Each channel is an enable-gated down-counter with its own terminal count. It runs in one of four modes: off, periodic tick, one-shot timer with busy handshake, or 50%-duty square clock.
- Provides all conversion-rate ticks and settling delays from one block, with a global phase-align input.

Parameters:
Width, 8, counter and terminal-count width per channel
Channels, 4, number of independent divider channels

Ports:
clk_i  input  1  system clock; all logic on rising edge
rst_i  input  1  asynchronous, active-low reset
sync_i  input  1  synchronous clear of all channels (phase align)
en_i  input  Channels  per-channel count enable (bit n = channel n)
kmax_i  input  Channels*Width  per-channel terminal count, channel n at bits [n*Width +: Width]
mode_i  input  2*Channels  per-channel mode, channel n at bits [2n +: 2]; 00 OFF, 01 PERIODIC, 10 ONESHOT, 11 SQUARE
start_i  input  Channels  one-shot trigger, sampled per clock
tick_o  output  Channels  registered one-cycle pulse per reload/expiry
sq_o  output  Channels  registered square clock (SQUARE mode only)
busy_o  output  Channels  registered one-shot in progress

Behaviour:
- Per-channel state: cnt (Width), busy, sq, tick, mode_q (registered copy of mode_i).
- rst_i low clears all state immediately, regardless of clock; tick_o, sq_o, busy_o = 0.
- Reset mid-operation aborts everything.
- After reset release, the first edge is normal operation.
- Priority per channel, highest first:
  - sync_i
  - mode change (mode_i != mode_q)
  - mode behaviour
- sync_i=1: cnt, busy, sq, tick <= 0 for all channels; mode_q <= mode_i.
- Mode change: that channel's cnt, busy, sq, tick <= 0 and mode_q <= mode_i; the new mode runs from the next edge.
- Reload event: en_i[n]=1 and cnt==0. kmax_i is sampled only on a reload or a start, so a mid-count kmax change takes effect at the next reload.
- Counting: with en_i[n]=1 and cnt!=0, cnt <= cnt-1. With en_i[n]=0, cnt, busy and sq freeze and tick <= 0.
- OFF:
  - cnt held 0; tick, sq, busy = 0.
  - start ignored.
- PERIODIC:
  - On a reload event: cnt <= kmax, tick <= 1; otherwise tick <= 0.
  - Period = kmax+1 enabled cycles.
  - First tick on the first enabled edge after reset/sync/mode change.
  - kmax=0: tick_o stays high while enabled.
  - sq and busy stay 0; start ignored.
- ONESHOT:
  - Idle (busy=0): cnt=0, tick=0. start_i[n]=1 loads cnt <= kmax, busy <= 1 (en not required for the load).
  - Busy, en=1, cnt!=0: decrement.
  - Busy, en=1, cnt==0: busy <= 0, tick <= 1 for one cycle.
  - tick_o asserts kmax+1 enabled edges after the edge that sampled start.
  - start while busy is ignored (no retrigger).
  - start on the expiry edge is also ignored; re-arming is possible from the following edge.
- SQUARE:
  - Same reload as PERIODIC; on each reload sq <= ~sq and tick <= 1.
  - sq_o period = 2*(kmax+1) enabled cycles, 50% duty.
  - sq_o starts low, and the first edge of the first reload drives it high.
- Channels are fully independent apart from sync_i.
- No arithmetic underflow: decrement occurs only when cnt!=0.

Test Plan:
- Width=8. Reset low mid-count in ch0 PERIODIC kmax=5 -> all outputs 0 immediately; after release with en=1, tick_o[0] pulses on the first edge, then every 6 edges.
- ch1 ONESHOT kmax=3, en=1, start pulse at edge E0 -> busy_o[1]=1 from E0 through E4; tick_o[1]=1 for exactly one cycle after E4. A second start at E2 changes nothing.
- ch2 SQUARE kmax=2, en=1 for 24 cycles -> sq_o[2] toggles every 3 edges (period 6), tick_o[2] coincides with each toggle. Then drop en for 5 cycles -> sq_o frozen and tick_o low; on resume the phase continues.
- ch3 PERIODIC kmax=0 -> tick_o[3] continuously high while en=1. kmax changed to 4 mid-run -> ticks every 5 edges.
- Channels 0 and 2 PERIODIC kmax=7 at differing phases; assert sync_i for one cycle -> both cnt=0; both tick_o pulse on the same next edge and stay aligned.
- ch1 switched from ONESHOT (busy, cnt=10) to PERIODIC -> busy_o drops next edge with no expiry tick; PERIODIC ticks start on the following edge.
